dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port, level-sensitive data memory (addr/rbar_w/write_data/read_data) between two requesters:
//  port 0 = CPU load/store stage, port 1 = debug/DMA loader. Serialises accesses, guarantees memory
//  control lines are stable and read-only when idle, returns registered read data with a done pulse.
// PARAMETERS
//  DATA_W    32   data width of memory and ports
//  ADDR_W    32   address width of ports and memory
//  DEPTH     256  memory words; addr >= DEPTH is an error
//  FIXED_PRI 0    0 = round-robin between ports; 1 = port 0 always wins
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  req0/req1      in   1       access request, held with operands until gnt
//  rbar_w0/1      in   1       1 = write, 0 = read
//  addr0/1        in   ADDR_W  word address
//  wdata0/1       in   DATA_W  write data
//  gnt0/1         out  1       one-cycle pulse: request accepted, operands latched
//  done0/1        out  1       one-cycle pulse: access complete
//  err0/1         out  1       valid with done: address out of range, access suppressed
//  rdata          out  DATA_W  read result, valid with done of a read; shared by both ports
//  mem_addr       out  ADDR_W  to memory addr
//  mem_rbar_w     out  1       to memory rbar_w
//  mem_write_data out  DATA_W  to memory write_data
//  mem_read_data  in   DATA_W  from memory read_data (combinational)
// BEHAVIOUR
//  Reset: state IDLE; gnt*/done*/err* = 0; rdata = 0; mem_rbar_w = 0; mem_addr = 0; mem_write_data = 0;
//   rr pointer -> port 0 preferred.
//  FSM IDLE -> ACCESS -> DONE -> IDLE; one access per 3 cycles max.
//  IDLE: at edge, if req0|req1: choose winner, latch rbar_w/addr/wdata, gnt<win>=1 next cycle, -> ACCESS.
//   Choice: FIXED_PRI=1 -> port 0; else the port not served last wins a tie; a lone request always wins.
//  ACCESS (1 cycle, gnt pulse visible): drive mem_addr/mem_write_data from latch;
//   mem_rbar_w = latched rbar_w unless out of range (then 0).
//   At edge: rdata <= read ? (oor ? 0 : mem_read_data) : rdata; -> DONE.
//  DONE (1 cycle): done<win>=1, err<win>=oor; mem_rbar_w=0; rr pointer updated; -> IDLE.
//  Latency: req sampled edge E -> gnt during E+1, done/rdata during E+2.
//  mem_rbar_w is 1 only in ACCESS for an in-range write; mem_addr holds its last value outside ACCESS
//   (no address toggling while idle).
//  Requester may drop req before gnt (withdrawn, no access); after gnt it may change operands freely.
//  req held high after done = new request, re-arbitrated in IDLE.
//  rdata holds until next read completes; writes do not alter it.
//  oor = |latched_addr[ADDR_W-1:$clog2(DEPTH)]; wrap-around is never applied.
//  rst during ACCESS: write presented that cycle still lands in memory; no done pulse; state -> IDLE.
//  rst during DONE: done suppressed at next edge; the pulse in progress already completed.
// STRUCTURE
//  Shared defs package dmem_arb_pkg: FSM state encoding (IDLE/ACCESS/DONE), port count NPORT=2, port ids.
//  Sub-module rr_arbiter2: 2-request arbiter with last-served pointer and FIXED_PRI mode,
//   outputs one-hot grant; reused by future bus arbiters.
//  Top: FSM, operand latch, rdata register, memory-side drive.
// TESTING (bench includes the real data_memory, initial Mem[i] = i)
//  Port0 read addr 5 alone -> gnt0 at E+1, done0 at E+2, rdata=5, err0=0, mem_rbar_w never 1.
//  Port1 write addr 10 data 0xDEAD_BEEF, then port0 read 10 -> rdata=0xDEADBEEF, done1 then done0.
//  req0 and req1 both held high, FIXED_PRI=0 -> grants alternate 0,1,0,1; with FIXED_PRI=1 -> port 0 starves port 1.
//  Port0 write addr 300 data 7 -> done0 with err0=1, mem_rbar_w stays 0, Mem[300 mod 256] still 44.
//  rst pulsed in ACCESS of a port1 read -> no done1; after reset gnt/done = 0, rdata = 0, next req served normally.
//  req1 raised for one cycle while ACCESS for port0 busy -> no gnt1, no access by port1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port count, port ids.
package dmem_arb_pkg;

  localparam int NPORT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request ports plus the shared read data.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0;
  logic              req1;
  logic              rbar_w0;
  logic              rbar_w1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req0, req1, rbar_w0, rbar_w1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata
  );

  modport slave (
    input  req0, req1, rbar_w0, rbar_w1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, err0, err1, rdata
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-request arbiter with a last-served pointer; FIXED_PRI=1 turns it into port-0-wins priority.
// The grant is combinational from the requests; the pointer only moves when update is strobed.
module rr_arbiter2
  import dmem_arb_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic             update,
  input  port_id_t         served,
  output logic [NPORT-1:0] gnt_oh
);

  port_id_t last_q;

  // Last-served pointer; reset value makes port 0 the preferred winner of a tie.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst)         last_q <= PORT1;
    else if (update) last_q <= served;
  end

  // One-hot grant: a lone request always wins, a tie goes to the port not served last.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    gnt_oh = '0;
    if (FIXED_PRI != 0 || req != 2'b11) begin
      if (req[0])      gnt_oh = 2'b01;
      else if (req[1]) gnt_oh = 2'b10;
    end else begin
      gnt_oh = (last_q == PORT0) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU (port 0) and debug/DMA (port 1) accesses onto a single-port, level-sensitive
// data memory. Each access runs IDLE -> ACCESS -> DONE; memory control lines only move in ACCESS.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 256,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rbar_w,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t            state_q, state_d;
  port_id_t          win_q, win_d;
  logic              lat_rbar_w_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [NPORT-1:0]  req_vec;
  logic [NPORT-1:0]  gnt_oh;
  logic [NPORT-1:0]  gnt, done, err;
  logic              oor;

  assign req_vec = {bus.req1, bus.req0};
  assign win_d   = gnt_oh[1] ? PORT1 : PORT0;
  // Out-of-range addresses are flagged, never wrapped onto a valid word.
  assign oor     = |lat_addr_q[ADDR_W-1:IDX_W];

  rr_arbiter2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .update (state_q == ST_DONE),
    .served (win_q),
    .gnt_oh (gnt_oh)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand latch: captured from the winner on the accepting edge, so requesters may change
  // operands freely once granted. It also feeds the memory, keeping its address still when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= PORT0;
      lat_rbar_w_q <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
    end else if (state_q == ST_IDLE && |gnt_oh) begin
      win_q        <= win_d;
      lat_rbar_w_q <= (win_d == PORT1) ? bus.rbar_w1 : bus.rbar_w0;
      lat_addr_q   <= (win_d == PORT1) ? bus.addr1   : bus.addr0;
      lat_wdata_q  <= (win_d == PORT1) ? bus.wdata1  : bus.wdata0;
    end
  end

  // Read data register: updated only by a completing read, held across writes.
  always_ff @(posedge clk) begin
    if (rst)                                     rdata_q <= '0;
    else if (state_q == ST_ACCESS && !lat_rbar_w_q) rdata_q <= oor ? '0 : mem_read_data;
  end

  // Next state and per-state outputs (grant pulse in ACCESS, done/err pulse in DONE).
  always_comb begin
    state_d    = state_q;
    gnt        = '0;
    done       = '0;
    err        = '0;
    mem_rbar_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        gnt[win_q] = 1'b1;
        mem_rbar_w = lat_rbar_w_q & ~oor;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        done[win_q] = 1'b1;
        err[win_q]  = oor;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr       = lat_addr_q;
  assign mem_write_data = lat_wdata_q;

  assign bus.gnt0  = gnt[0];
  assign bus.gnt1  = gnt[1];
  assign bus.done0 = done[0];
  assign bus.done1 = done[1];
  assign bus.err0  = err[0];
  assign bus.err1  = err[1];
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance (dut) checked against a done-time scoreboard,
// plus a fixed-priority instance (dut_fp) used for the starvation scenario. Each instance has
// its own level-sensitive memory model initialised with Mem[i] = i.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef struct packed {
    logic              port;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_load = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

  logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
  logic              mem_rbar_w_a, mem_rbar_w_b;
  logic [DATA_W-1:0] mem_write_data_a, mem_write_data_b;
  logic [DATA_W-1:0] mem_read_data_a, mem_read_data_b;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FIXED_PRI(0)) dut (
    .clk(clk), .rst(rst), .bus(bus_a),
    .mem_addr(mem_addr_a), .mem_rbar_w(mem_rbar_w_a),
    .mem_write_data(mem_write_data_a), .mem_read_data(mem_read_data_a)
  );

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_b),
    .mem_addr(mem_addr_b), .mem_rbar_w(mem_rbar_w_b),
    .mem_write_data(mem_write_data_b), .mem_read_data(mem_read_data_b)
  );

  // Memory models: combinational read, write on the edge while rbar_w is high.
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                wr_count_a = 0;

  assign mem_read_data_a = mem_a[mem_addr_a[IDX_W-1:0]];
  assign mem_read_data_b = mem_b[mem_addr_b[IDX_W-1:0]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= DATA_W'(i);
        mem_b[i] <= DATA_W'(i);
      end
    end else begin
      if (mem_rbar_w_a) begin
        mem_a[mem_addr_a[IDX_W-1:0]] <= mem_write_data_a;
        wr_count_a <= wr_count_a + 1;
      end
      if (mem_rbar_w_b) mem_b[mem_addr_b[IDX_W-1:0]] <= mem_write_data_b;
    end
  end

  int                n_checks = 0;
  int                n_fail   = 0;
  exp_t              sb_q [$];
  exp_t              mon_e;
  logic [DATA_W-1:0] exp_last_rdata = '0;

  // Scoreboard monitor: every done pulse on dut must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && (bus_a.done0 || bus_a.done1)) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: got done1/done0=%b%b, required none pending",
                 bus_a.done1, bus_a.done0);
      end else begin
        mon_e = sb_q.pop_front();
        if ({bus_a.done1, bus_a.done0} !== (mon_e.port ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL sb_done_port: got done1/done0=%b%b, required port %0d",
                   bus_a.done1, bus_a.done0, mon_e.port);
        end
        n_checks++;
        if ({bus_a.err1, bus_a.err0} !== {mon_e.port & mon_e.err, ~mon_e.port & mon_e.err}) begin
          n_fail++;
          $display("FAIL sb_err: got err1/err0=%b%b, required err=%b on port %0d",
                   bus_a.err1, bus_a.err0, mon_e.err, mon_e.port);
        end
        n_checks++;
        if (bus_a.rdata !== mon_e.rdata) begin
          n_fail++;
          $display("FAIL sb_rdata: got 0x%08h, required 0x%08h", bus_a.rdata, mon_e.rdata);
        end
      end
    end
  end

  // Drive one request on dut; optionally push its expectation; return at the negedge the
  // grant is seen (lat = negedges counted since driving, 20 if it never came).
  task automatic issue(input bit port, input bit is_wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input bit expect_done, output int lat);
    exp_t e;
    bit   oor_l;
    oor_l = (addr >= ADDR_W'(DEPTH));
    if (expect_done) begin
      if (!is_wr)      exp_last_rdata = oor_l ? '0 : ref_mem[addr[IDX_W-1:0]];
      else if (!oor_l) ref_mem[addr[IDX_W-1:0]] = wdata;
      e.port  = port;
      e.err   = oor_l;
      e.rdata = exp_last_rdata;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    if (!port) begin
      bus_a.req0 = 1'b1; bus_a.rbar_w0 = is_wr; bus_a.addr0 = addr; bus_a.wdata0 = wdata;
    end else begin
      bus_a.req1 = 1'b1; bus_a.rbar_w1 = is_wr; bus_a.addr1 = addr; bus_a.wdata1 = wdata;
    end
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (port ? bus_a.gnt1 : bus_a.gnt0) break;
    end
    if (!port) bus_a.req0 = 1'b0;
    else       bus_a.req1 = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to empty, then let the FSM settle in IDLE.
  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb_q.delete();
    exp_last_rdata = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 mem_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_a.gnt1, bus_a.gnt0, bus_a.done1, bus_a.done0, bus_a.err1, bus_a.err0} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags_a: got %b, required 000000",
               {bus_a.gnt1, bus_a.gnt0, bus_a.done1, bus_a.done0, bus_a.err1, bus_a.err0});
    end
    n_checks++;
    if ({bus_b.gnt1, bus_b.gnt0, bus_b.done1, bus_b.done0, bus_b.err1, bus_b.err0} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags_b: got %b, required 000000",
               {bus_b.gnt1, bus_b.gnt0, bus_b.done1, bus_b.done0, bus_b.err1, bus_b.err0});
    end
    n_checks++;
    if (bus_a.rdata !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got 0x%08h, required 0", bus_a.rdata);
    end
    n_checks++;
    if (mem_rbar_w_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_rbar_w: got %b, required 0", mem_rbar_w_a);
    end
    n_checks++;
    if (mem_addr_a !== '0) begin
      n_fail++; $display("FAIL reset_mem_addr: got 0x%08h, required 0", mem_addr_a);
    end
    n_checks++;
    if (mem_write_data_a !== '0) begin
      n_fail++; $display("FAIL reset_mem_write_data: got 0x%08h, required 0", mem_write_data_a);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single_read();
    int lat;
    int w0;
    w0 = wr_count_a;
    issue(1'b0, 1'b0, 32'd5, '0, 1'b1, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL read5_gnt_latency: got %0d, required 2", lat);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_a.done1, bus_a.done0} !== 2'b01) begin
      n_fail++; $display("FAIL read5_done_cycle: got %b%b, required 01", bus_a.done1, bus_a.done0);
    end
    drain();
    issue(1'b1, 1'b0, 32'd255, '0, 1'b1, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL read255_gnt_latency: got %0d, required 2", lat);
    end
    drain();
    n_checks++;
    if (wr_count_a !== w0) begin
      n_fail++; $display("FAIL read_no_write: got %0d writes, required %0d", wr_count_a, w0);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL read_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_write_then_read();
    int lat;
    issue(1'b1, 1'b1, 32'd10, 32'hDEAD_BEEF, 1'b1, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL wr10_gnt_latency: got %0d, required 2", lat);
    end
    issue(1'b0, 1'b0, 32'd10, '0, 1'b1, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL rd10_gnt_latency: got %0d, required 3", lat);
    end
    drain();
    n_checks++;
    if (mem_a[10] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr10_mem: got 0x%08h, required 0xdeadbeef", mem_a[10]);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL wr_rd_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit   seq_a [4];
    bit   seq_b [4];
    int   cnt_a;
    int   cnt_b;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      e.port  = k[0];
      e.err   = 1'b0;
      e.rdata = ref_mem[k[0] ? 2 : 1];
      exp_last_rdata = e.rdata;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus_a.req0 = 1'b1; bus_a.rbar_w0 = 1'b0; bus_a.addr0 = 32'd1;
    bus_a.req1 = 1'b1; bus_a.rbar_w1 = 1'b0; bus_a.addr1 = 32'd2;
    bus_b.req0 = 1'b1; bus_b.rbar_w0 = 1'b0; bus_b.addr0 = 32'd1;
    bus_b.req1 = 1'b1; bus_b.rbar_w1 = 1'b0; bus_b.addr1 = 32'd2;
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 40 && cnt_a < 4; c++) begin
      @(negedge clk);
      if (bus_a.gnt0 || bus_a.gnt1) begin
        if (cnt_a < 4) seq_a[cnt_a] = bus_a.gnt1;
        cnt_a++;
      end
      if (bus_b.gnt0 || bus_b.gnt1) begin
        if (cnt_b < 4) seq_b[cnt_b] = bus_b.gnt1;
        cnt_b++;
      end
    end
    bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
    bus_b.req0 = 1'b0; bus_b.req1 = 1'b0;
    n_checks++;
    if (cnt_a !== 4 || cnt_b !== 4) begin
      n_fail++; $display("FAIL rr_grant_count: got a=%0d b=%0d, required 4 each", cnt_a, cnt_b);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (seq_a[k] !== k[0]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got port %0d, required port %0d", k, seq_a[k], k[0]);
        end
        n_checks++;
        if (seq_b[k] !== 1'b0) begin
          n_fail++; $display("FAIL fixed_pri_order[%0d]: got port %0d, required port 0", k, seq_b[k]);
        end
      end
    end
    drain();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL rr_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_oor_write();
    int lat;
    int w0;
    w0 = wr_count_a;
    issue(1'b0, 1'b1, 32'd300, 32'd7, 1'b1, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL oor_wr_gnt_latency: got %0d, required 2", lat);
    end
    drain();
    issue(1'b1, 1'b0, 32'd256, '0, 1'b1, lat);
    drain();
    n_checks++;
    if (wr_count_a !== w0) begin
      n_fail++; $display("FAIL oor_mem_rbar_w: got %0d writes, required %0d", wr_count_a, w0);
    end
    n_checks++;
    if (mem_a[44] !== 32'd44) begin
      n_fail++; $display("FAIL oor_no_wrap: got Mem[44]=0x%08h, required 0x0000002c", mem_a[44]);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL oor_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_in_access();
    int lat;
    int n_done;
    issue(1'b1, 1'b0, 32'd20, '0, 1'b0, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL rst_rd_gnt_latency: got %0d, required 2", lat);
    end
    rst = 1'b1;
    sb_q.delete();
    exp_last_rdata = '0;
    @(posedge clk); #1 rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_a.done0 || bus_a.done1 || bus_a.gnt0 || bus_a.gnt1) n_done++;
    end
    n_checks++;
    if (n_done !== 0) begin
      n_fail++; $display("FAIL rst_access_no_done: got %0d pulses, required 0", n_done);
    end
    n_checks++;
    if (bus_a.rdata !== '0) begin
      n_fail++; $display("FAIL rst_access_rdata: got 0x%08h, required 0", bus_a.rdata);
    end
    issue(1'b1, 1'b1, 32'd30, 32'h0000_1234, 1'b0, lat);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ref_mem[30] = 32'h0000_1234;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_a[30] !== 32'h0000_1234) begin
      n_fail++; $display("FAIL rst_access_write_lands: got 0x%08h, required 0x00001234", mem_a[30]);
    end
    issue(1'b0, 1'b0, 32'd30, '0, 1'b1, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL post_rst_gnt_latency: got %0d, required 2", lat);
    end
    drain();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL post_rst_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_withdrawn();
    int lat;
    int w0;
    int n_gnt1;
    w0 = wr_count_a;
    issue(1'b0, 1'b0, 32'd3, '0, 1'b1, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL wd_gnt_latency: got %0d, required 2", lat);
    end
    bus_a.req1 = 1'b1; bus_a.rbar_w1 = 1'b1; bus_a.addr1 = 32'd50; bus_a.wdata1 = 32'h0000_0BAD;
    @(negedge clk);
    bus_a.req1 = 1'b0;
    n_gnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_a.gnt1) n_gnt1++;
    end
    n_checks++;
    if (n_gnt1 !== 0) begin
      n_fail++; $display("FAIL withdrawn_no_gnt1: got %0d grants, required 0", n_gnt1);
    end
    n_checks++;
    if (wr_count_a !== w0 || mem_a[50] !== 32'd50) begin
      n_fail++; $display("FAIL withdrawn_no_access: got writes=%0d Mem[50]=0x%08h, required %0d and 0x00000032",
                         wr_count_a, mem_a[50], w0);
    end
    drain();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL withdrawn_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'(i);
    bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.rbar_w0 = 1'b0; bus_a.rbar_w1 = 1'b0;
    bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.wdata0 = '0; bus_a.wdata1 = '0;
    bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.rbar_w0 = 1'b0; bus_b.rbar_w1 = 1'b0;
    bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.wdata0 = '0; bus_b.wdata1 = '0;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_round_robin();
    test_oor_write();
    test_reset_in_access();
    test_withdrawn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

endmodule
